fe_capture_ctrl: RTL

//  Front-end capture sequencer in the fe_clk domain: arm -> wait trigger -> capture N events -> done.

---
 rtl/fe_capture_ctrl_pkg.sv | 28 ++
 rtl/fe_delta_timer.sv | 33 +++
 rtl/fe_capture_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_capture_ctrl_pkg.sv
// rtl/fe_capture_ctrl_pkg.sv - shared types and codes for the front-end capture controller
// Purpose : state encoding, sniff-FIFO command codes, event record and a cmd helper.
// Ports   : none (package).
package fe_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    FE_CAP_IDLE    = 2'd0,
    FE_CAP_ARMED   = 2'd1,
    FE_CAP_CAPTURE = 2'd2,
    FE_CAP_DONE    = 2'd3
  } fe_cap_state_t;

  // 0 is left unused so an idle FIFO bus never looks like a valid command.
  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd1;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd2;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd3;

  typedef struct packed {
    logic       is_stat;
    logic [7:0] data;
    logic [4:0] stat;
  } fe_event_t;

  function automatic logic [1:0] fe_event_cmd(input logic is_stat);
    return is_stat ? FE_FIFO_CMD_STAT : FE_FIFO_CMD_DATA;
  endfunction

endpackage

// File: rtl/fe_delta_timer.sv
// rtl/fe_delta_timer.sv - saturating delta-timestamp counter
// Purpose : counts enabled cycles since the last clear, sticking at all-ones.
// Ports   : i_clk, i_rst (async, active-high), i_clear (priority over enable),
//           i_enable, o_delta (current count), o_sat (count is all-ones).
module fe_delta_timer #(
  parameter int pWIDTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [pWIDTH-1:0] o_delta,
  output logic              o_sat
);

  localparam logic [pWIDTH-1:0] LP_ONE = {{(pWIDTH-1){1'b0}}, 1'b1};

  logic [pWIDTH-1:0] r_delta;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_delta <= '0;
    end else if (i_clear) begin
      r_delta <= '0;
    end else if (i_enable && !o_sat) begin
      r_delta <= r_delta + LP_ONE;
    end
  end

  assign o_delta = r_delta;
  assign o_sat   = &r_delta;

endmodule

// File: rtl/fe_capture_ctrl.sv
// rtl/fe_capture_ctrl.sv - front-end capture sequencer feeding the sniff FIFO write port
// Purpose : arm -> wait trigger -> capture N events -> done; turns DATA/STAT events into
//           FIFO writes with delta timestamps, inserting TIME entries for long deltas and
//           keepalives, stopping cleanly on FIFO full.
// Ports   : fe_clk, reset_i (async, active-high); control I_arm, I_abort, I_trigger,
//           I_capture_len, I_timestamps_disable, I_timeout_cycles; event input
//           I_event_valid/is_stat/data/stat; I_fifo_full; FIFO write O_fifo_wr/cmd/time/
//           data/stat; status O_capture_enable, O_state, O_event_count, O_overflow, O_timeout.
// Config  : CAPTURE_TIMEOUT_EN enables the idle-timeout counter; otherwise O_timeout is 0.
module fe_capture_ctrl
  import fe_capture_ctrl_pkg::*;
#(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pCOUNT_WIDTH           = 20,
  parameter int pTIMEOUT_WIDTH         = 24
) (
  input  logic                             fe_clk,
  input  logic                             reset_i,
  input  logic                             I_arm,
  input  logic                             I_abort,
  input  logic                             I_trigger,
  input  logic [pCOUNT_WIDTH-1:0]          I_capture_len,
  input  logic                             I_timestamps_disable,
  input  logic                             I_event_valid,
  input  logic                             I_event_is_stat,
  input  logic [7:0]                       I_event_data,
  input  logic [4:0]                       I_event_stat,
  input  logic                             I_fifo_full,
  input  logic [pTIMEOUT_WIDTH-1:0]        I_timeout_cycles,
  output logic                             O_capture_enable,
  output logic                             O_fifo_wr,
  output logic [1:0]                       O_fifo_cmd,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
  output logic [7:0]                       O_fifo_data,
  output logic [4:0]                       O_fifo_stat,
  output logic [1:0]                       O_state,
  output logic [pCOUNT_WIDTH-1:0]          O_event_count,
  output logic                             O_overflow,
  output logic                             O_timeout
);

  localparam int TW = pTIMESTAMP_FULL_WIDTH;
  localparam logic [TW-1:0] LP_SHORT_MAX =
    {{(TW-pTIMESTAMP_SHORT_WIDTH){1'b0}}, {pTIMESTAMP_SHORT_WIDTH{1'b1}}};
  localparam logic [pCOUNT_WIDTH:0] LP_CNT_ONE = {{pCOUNT_WIDTH{1'b0}}, 1'b1};

  fe_cap_state_t r_state;
  fe_cap_state_t w_state_next;

  logic [TW-1:0] w_delta;
  logic          w_delta_sat;
  logic          w_delta_clear;
  logic          w_delta_en;

  fe_event_t     w_in_event;
  fe_event_t     r_pend;
  logic          r_pend_valid;

  logic          w_need;
  logic          w_wr;
  logic [1:0]    w_cmd;
  logic [TW-1:0] w_time;
  logic [7:0]    w_data;
  logic [4:0]    w_stat;
  logic          w_pend_load;
  logic          w_pend_flush;
  logic          w_drop;
  logic          w_full_stop;
  logic          w_count_inc;
  logic          w_len_hit;
  logic          w_arm_accept;
  logic          w_timeout_hit;
  logic [pCOUNT_WIDTH:0] w_count_plus;

  logic                    r_fifo_wr;
  logic [1:0]              r_fifo_cmd;
  logic [TW-1:0]           r_fifo_time;
  logic [7:0]              r_fifo_data;
  logic [4:0]              r_fifo_stat;
  logic [pCOUNT_WIDTH-1:0] r_count;
  logic                    r_overflow;
  logic                    r_timeout;
  logic                    r_capture_enable;

  assign w_in_event   = {I_event_is_stat, I_event_data, I_event_stat};
  assign w_arm_accept = I_arm && ((r_state == FE_CAP_IDLE) || (r_state == FE_CAP_DONE));
  assign w_count_plus = {1'b0, r_count} + LP_CNT_ONE;
  assign w_len_hit    = w_count_inc && (I_capture_len != '0) &&
                        (w_count_plus >= {1'b0, I_capture_len});

  // Delta runs only in CAPTURE; held at zero otherwise so entry starts from 0,
  // and cleared whenever a write goes out so the next entry is relative to it.
  assign w_delta_clear = (r_state != FE_CAP_CAPTURE) || w_wr;
  assign w_delta_en    = (r_state == FE_CAP_CAPTURE);

  fe_delta_timer #(.pWIDTH(TW)) u_delta_timer (
    .i_clk    (fe_clk),
    .i_rst    (reset_i),
    .i_clear  (w_delta_clear),
    .i_enable (w_delta_en),
    .o_delta  (w_delta),
    .o_sat    (w_delta_sat)
  );

`ifdef CAPTURE_TIMEOUT_EN
  localparam logic [pTIMEOUT_WIDTH-1:0] LP_IDLE_ONE = {{(pTIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  logic [pTIMEOUT_WIDTH-1:0] r_idle;
  logic [pTIMEOUT_WIDTH-1:0] w_idle_next;

  always_comb begin
    w_idle_next = r_idle;
    if ((r_state != FE_CAP_CAPTURE) || I_event_valid) begin
      w_idle_next = '0;
    end else if (~&r_idle) begin
      w_idle_next = r_idle + LP_IDLE_ONE;
    end
  end

  assign w_timeout_hit = (r_state == FE_CAP_CAPTURE) && !I_abort &&
                         (I_timeout_cycles != '0) && (w_idle_next == I_timeout_cycles);

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_idle <= '0;
    end else begin
      r_idle <= (w_state_next == FE_CAP_CAPTURE) ? w_idle_next : '0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^I_timeout_cycles;
  assign w_timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state <= FE_CAP_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort has priority over trigger and over any capture stop reason.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FE_CAP_IDLE, FE_CAP_DONE: begin
        if (I_arm) w_state_next = FE_CAP_ARMED;
      end
      FE_CAP_ARMED: begin
        if (I_abort)        w_state_next = FE_CAP_IDLE;
        else if (I_trigger) w_state_next = FE_CAP_CAPTURE;
      end
      FE_CAP_CAPTURE: begin
        if (I_abort || w_full_stop || w_len_hit || w_timeout_hit) w_state_next = FE_CAP_DONE;
      end
      default: w_state_next = FE_CAP_IDLE;
    endcase
  end

  // Write decision for this cycle. A held (pending) event always goes out before
  // anything new; a long delta is flushed as a TIME entry ahead of its event.
  always_comb begin
    w_need       = 1'b0;
    w_wr         = 1'b0;
    w_cmd        = '0;
    w_time       = '0;
    w_data       = '0;
    w_stat       = '0;
    w_pend_load  = 1'b0;
    w_pend_flush = 1'b0;
    w_drop       = 1'b0;
    w_full_stop  = 1'b0;
    w_count_inc  = 1'b0;
    if ((r_state == FE_CAP_CAPTURE) && !I_abort) begin
      if (r_pend_valid) begin
        w_need       = 1'b1;
        w_pend_flush = 1'b1;
        w_count_inc  = 1'b1;
        w_cmd        = fe_event_cmd(r_pend.is_stat);
        w_data       = r_pend.is_stat ? 8'h00 : r_pend.data;
        w_stat       = r_pend.stat;
        w_drop       = I_event_valid;
      end else if (I_event_valid) begin
        w_need = 1'b1;
        if (!I_timestamps_disable && (w_delta > LP_SHORT_MAX)) begin
          w_cmd       = FE_FIFO_CMD_TIME;
          w_time      = w_delta;
          w_pend_load = 1'b1;
        end else begin
          w_count_inc = 1'b1;
          w_cmd       = fe_event_cmd(I_event_is_stat);
          w_time      = I_timestamps_disable ? '0 : w_delta;
          w_data      = I_event_is_stat ? 8'h00 : I_event_data;
          w_stat      = I_event_stat;
        end
      end else if (!I_timestamps_disable && w_delta_sat) begin
        w_need = 1'b1;
        w_cmd  = FE_FIFO_CMD_TIME;
        w_time = w_delta;
      end

      if (w_need && I_fifo_full) begin
        w_full_stop = 1'b1;
        w_count_inc = 1'b0;
        w_pend_load = 1'b0;
        w_cmd       = '0;
        w_time      = '0;
        w_data      = '0;
        w_stat      = '0;
      end else begin
        w_wr = w_need;
      end
    end
  end

  // Registered outputs and capture bookkeeping.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_fifo_wr        <= 1'b0;
      r_fifo_cmd       <= '0;
      r_fifo_time      <= '0;
      r_fifo_data      <= '0;
      r_fifo_stat      <= '0;
      r_count          <= '0;
      r_overflow       <= 1'b0;
      r_timeout        <= 1'b0;
      r_capture_enable <= 1'b0;
      r_pend_valid     <= 1'b0;
      r_pend           <= '0;
    end else begin
      r_fifo_wr        <= w_wr;
      r_fifo_cmd       <= w_cmd;
      r_fifo_time      <= w_time;
      r_fifo_data      <= w_data;
      r_fifo_stat      <= w_stat;
      r_capture_enable <= (w_state_next == FE_CAP_CAPTURE);
      // Pending survives only while capture continues; abort/stop drops it.
      r_pend_valid     <= (w_state_next == FE_CAP_CAPTURE) &&
                          (w_pend_load || (r_pend_valid && !w_pend_flush));
      if (w_pend_load) r_pend <= w_in_event;

      if (w_arm_accept) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_timeout  <= 1'b0;
      end else begin
        if (w_count_inc && !(&r_count)) r_count <= w_count_plus[pCOUNT_WIDTH-1:0];
        if (w_drop || w_full_stop) r_overflow <= 1'b1;
        if (w_timeout_hit) r_timeout <= 1'b1;
      end
    end
  end

  assign O_state          = r_state;
  assign O_capture_enable = r_capture_enable;
  assign O_fifo_wr        = r_fifo_wr;
  assign O_fifo_cmd       = r_fifo_cmd;
  assign O_fifo_time      = r_fifo_time;
  assign O_fifo_data      = r_fifo_data;
  assign O_fifo_stat      = r_fifo_stat;
  assign O_event_count    = r_count;
  assign O_overflow       = r_overflow;
  assign O_timeout        = r_timeout;

endmodule
